// File: rtl/apb_i2s_rx_if.sv
`timescale 1ns/1ps
// APB bus bundle for apb_i2s_rx: 6-bit address, 32-bit data, slave always ready.
interface apb_i2s_rx_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [5:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_i2s_rx.sv
`timescale 1ns/1ps
// APB slave that receives Philips I2S stereo words into per-channel FIFOs.
// Optional feature macro: APB_I2S_RX_IRQ_EN adds o_irq and CR.IRQ_EN (bit2).
module apb_i2s_rx #(
    parameter int FIFO_AW     = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    apb_i2s_rx_if.slave apb,
    input  logic        i_sck,
    input  logic        i_ws,
    input  logic        i_sd
`ifdef APB_I2S_RX_IRQ_EN
    ,
    output logic        o_irq
`endif
);
    localparam int DEPTH = 1 << FIFO_AW;

    logic [SYNC_STAGES-1:0] sck_sync, ws_sync, sd_sync;
    logic                   sck_s, ws_s, sd_s, sck_d, sck_rise;
    logic                   rx_en, irq_en, ovr, frm;
    logic [31:0]            shift_reg, word_p0;
    logic [5:0]             bit_cnt, cnt_inc;
    logic                   ws_prev, ws_vld, synced;
    logic                   push_l_p0, push_r_p0, frm_p0;
    logic [31:0]            mem [2][DEPTH];
    logic [FIFO_AW:0]       wp [2];
    logic [FIFO_AW:0]       rp [2];
    logic [1:0]             empty, full, push, pop, wr_ok;
    logic [3:0]             reg_sel;
    logic                   rd_acc, wr_acc, cr_wr, clr_err;
    logic                   unused_bits;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign ws_s     = ws_sync[SYNC_STAGES-1];
    assign sd_s     = sd_sync[SYNC_STAGES-1];
    assign sck_rise = rx_en & sck_s & ~sck_d;
    assign cnt_inc  = (bit_cnt == 6'd33) ? 6'd33 : bit_cnt + 6'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sck_sync <= '0;
            ws_sync  <= '0;
            sd_sync  <= '0;
            sck_d    <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], i_sck};
            ws_sync  <= {ws_sync[SYNC_STAGES-2:0], i_ws};
            sd_sync  <= {sd_sync[SYNC_STAGES-2:0], i_sd};
            sck_d    <= sck_s;
        end
    end

    // Bit receiver: a WS change closes the word of the previous channel;
    // words are only trusted once a first WS change has aligned the counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            ws_prev   <= 1'b0;
            ws_vld    <= 1'b0;
            synced    <= 1'b0;
            push_l_p0 <= 1'b0;
            push_r_p0 <= 1'b0;
            frm_p0    <= 1'b0;
        end else begin
            push_l_p0 <= 1'b0;
            push_r_p0 <= 1'b0;
            frm_p0    <= 1'b0;
            if (!rx_en) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
                ws_vld    <= 1'b0;
                synced    <= 1'b0;
            end else if (sck_rise) begin
                shift_reg <= {shift_reg[30:0], sd_s};
                ws_prev   <= ws_s;
                ws_vld    <= 1'b1;
                if (ws_vld && (ws_s != ws_prev)) begin
                    bit_cnt <= '0;
                    synced  <= 1'b1;
                    if (synced) begin
                        if (cnt_inc == 6'd32) begin
                            push_l_p0 <= ~ws_prev;
                            push_r_p0 <= ws_prev;
                        end else begin
                            frm_p0 <= 1'b1;
                        end
                    end
                end else begin
                    bit_cnt <= cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (sck_rise) word_p0 <= {shift_reg[30:0], sd_s};
    end

    // APB decode and FIFO status
    assign reg_sel     = apb.paddr[5:2];
    assign rd_acc      = apb.psel & apb.penable & ~apb.pwrite;
    assign wr_acc      = apb.psel & apb.penable & apb.pwrite;
    assign cr_wr       = wr_acc && (reg_sel == 4'd0);
    assign clr_err     = cr_wr && apb.pwdata[1];
    assign push        = {push_r_p0, push_l_p0};
    assign apb.pready  = 1'b1;
    assign apb.pslverr = 1'b0;
    assign unused_bits = ^{apb.pwdata[31:2], apb.paddr[1:0], shift_reg[31]};

    always_comb begin
        empty = '0;
        full  = '0;
        pop   = '0;
        wr_ok = '0;
        for (int c = 0; c < 2; c++) begin
            empty[c] = (wp[c] == rp[c]);
            full[c]  = (wp[c][FIFO_AW] != rp[c][FIFO_AW]) &&
                       (wp[c][FIFO_AW-1:0] == rp[c][FIFO_AW-1:0]);
            pop[c]   = rd_acc && (reg_sel == ((c == 0) ? 4'd2 : 4'd3)) && !empty[c];
            wr_ok[c] = push[c] && (!full[c] || pop[c]);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < 2; c++) begin
                wp[c] <= '0;
                rp[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (wr_ok[c]) wp[c] <= wp[c] + 1'b1;
                if (pop[c])   rp[c] <= rp[c] + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int c = 0; c < 2; c++) begin
            if (wr_ok[c]) mem[c][wp[c][FIFO_AW-1:0]] <= word_p0;
        end
    end

    // Control/status: a fresh error wins over a same-cycle clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_en <= 1'b0;
            ovr   <= 1'b0;
            frm   <= 1'b0;
        end else begin
            if (cr_wr) rx_en <= apb.pwdata[0];
            ovr <= (ovr & ~clr_err) | (|(push & full & ~pop));
            frm <= (frm & ~clr_err) | frm_p0;
        end
    end

`ifdef APB_I2S_RX_IRQ_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            irq_en <= 1'b0;
            o_irq  <= 1'b0;
        end else begin
            if (cr_wr) irq_en <= apb.pwdata[2];
            o_irq <= irq_en & ((~empty[0] & ~empty[1]) | ovr | frm);
        end
    end
`else
    assign irq_en = 1'b0;
`endif

    always_comb begin
        apb.prdata = '0;
        if (apb.psel && !apb.pwrite) begin
            case (reg_sel)
                4'd0: apb.prdata = {29'd0, irq_en, 1'b0, rx_en};
                4'd1: apb.prdata = {26'd0, frm, ovr, full[1], empty[1], full[0], empty[0]};
                4'd2: if (!empty[0]) apb.prdata = mem[0][rp[0][FIFO_AW-1:0]];
                4'd3: if (!empty[1]) apb.prdata = mem[1][rp[1][FIFO_AW-1:0]];
                default: apb.prdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_i2s_rx.sv
`timescale 1ns/1ps
// Bench for apb_i2s_rx: register table, directed I2S scenarios and a random
// phase checked against a word-level receiver model.
module tb_apb_i2s_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sck = 1'b0, ws = 1'b0, sd = 1'b0;
`ifdef APB_I2S_RX_IRQ_EN
    logic irq;
`endif

    always #5 clk = ~clk;

    apb_i2s_rx_if bus();

    apb_i2s_rx #(.FIFO_AW(2), .SYNC_STAGES(2)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .apb     (bus),
        .i_sck   (sck),
        .i_ws    (ws),
        .i_sd    (sd)
`ifdef APB_I2S_RX_IRQ_EN
        ,
        .o_irq   (irq)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Word-level reference model
    logic [31:0] ql[$];
    logic [31:0] qr[$];
    bit m_ovr = 0, m_frm = 0, m_en = 0, armed = 0;
    int tx_pos = -1;
    bit tx_ch = 0;

    typedef struct {
        logic [5:0]  addr;
        bit          wr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model_sr();
        return {26'd0, m_frm, m_ovr, (qr.size() == 4), (qr.size() == 0),
                (ql.size() == 4), (ql.size() == 0)};
    endfunction

    task automatic model_word(input logic [31:0] d, input bit ch, input int n);
        if (!m_en) armed = 0;
        else if (!armed) armed = 1;
        else if (n != 32) m_frm = 1;
        else if (ch == 0) begin
            if (ql.size() == 4) m_ovr = 1; else ql.push_back(d);
        end else begin
            if (qr.size() == 4) m_ovr = 1; else qr.push_back(d);
        end
    endtask

    task automatic apb_write(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.psel = 1; bus.pwrite = 1; bus.penable = 0; bus.paddr = a; bus.pwdata = d;
        @(negedge clk);
        bus.penable = 1;
        @(negedge clk);
        bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
    endtask

    task automatic apb_read(input logic [5:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.psel = 1; bus.pwrite = 0; bus.penable = 0; bus.paddr = a;
        @(negedge clk);
        bus.penable = 1;
        #1 d = bus.prdata;
        @(negedge clk);
        bus.psel = 0; bus.penable = 0;
    endtask

    task automatic cr_write(input logic [31:0] d);
        apb_write(6'h00, d);
        m_en = d[0];
        if (d[1]) begin m_ovr = 0; m_frm = 0; end
    endtask

    task automatic rd_fifo(input bit ch, input string nm);
        logic [31:0] got, exp;
        apb_read(ch ? 6'h0C : 6'h08, got);
        exp = 32'd0;
        if (ch && qr.size() > 0) exp = qr.pop_front();
        else if (!ch && ql.size() > 0) exp = ql.pop_front();
        check(nm, got, exp);
    endtask

    task automatic rd_sr(input string nm);
        logic [31:0] got;
        apb_read(6'h04, got);
        check(nm, got, model_sr());
    endtask

    // Philips timing: WS flips on the LSB slot of the word it closes
    task automatic send_word(input logic [31:0] d, input bit ch, input int n);
        logic [63:0] dx;
        dx = {32'd0, d};
        for (int i = n - 1; i >= 0; i--) begin
            tx_ch = ch; tx_pos = i;
            sd = dx[i];
            ws = (i == 0) ? ~ch : ch;
            #40 sck = 1;
            #40 sck = 0;
        end
        tx_pos = -1;
        model_word(d, ch, n);
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r,
                              input int nl, input int nr);
        send_word(l, 0, nl);
        send_word(r, 1, nr);
        repeat (8) @(negedge clk);
    endtask

    function automatic int pick_len();
        int k;
        k = $urandom_range(0, 7);
        return (k == 0) ? 31 : ((k == 1) ? 33 : 32);
    endfunction

    initial begin
        #900us;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] got, sr_a, l, r;
        bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = '0; bus.pwdata = '0;

        tbl[0]  = '{6'h00, 0, 32'h0,        32'h0, "cr_rst"};
        tbl[1]  = '{6'h04, 0, 32'h0,        32'h5, "sr_rst"};
        tbl[2]  = '{6'h08, 0, 32'h0,        32'h0, "rxl_empty"};
        tbl[3]  = '{6'h0C, 0, 32'h0,        32'h0, "rxr_empty"};
        tbl[4]  = '{6'h10, 0, 32'h0,        32'h0, "unmapped_rd"};
        tbl[5]  = '{6'h00, 1, 32'hFFFFFFFE, 32'h0, "cr_wr_hi"};
`ifdef APB_I2S_RX_IRQ_EN
        tbl[6]  = '{6'h00, 0, 32'h0,        32'h4, "cr_rd_hi"};
`else
        tbl[6]  = '{6'h00, 0, 32'h0,        32'h0, "cr_rd_hi"};
`endif
        tbl[7]  = '{6'h04, 1, 32'hFFFFFFFF, 32'h0, "sr_wr"};
        tbl[8]  = '{6'h04, 0, 32'h0,        32'h5, "sr_ro"};
        tbl[9]  = '{6'h3C, 1, 32'hFFFFFFFF, 32'h0, "unmapped_wr"};
        tbl[10] = '{6'h3C, 0, 32'h0,        32'h0, "unmapped_rd2"};
        tbl[11] = '{6'h00, 1, 32'h1,        32'h0, "cr_en_wr"};
        tbl[12] = '{6'h00, 0, 32'h0,        32'h1, "cr_en_rd"};

        #23;
        check("rst_prdata", bus.prdata, 32'h0);
        check("rst_pready", {31'd0, bus.pready}, 32'h1);
        check("rst_pslverr", {31'd0, bus.pslverr}, 32'h0);
`ifdef APB_I2S_RX_IRQ_EN
        check("rst_irq", {31'd0, irq}, 32'h0);
`endif
        @(negedge clk) rst_n = 1;

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].wr) apb_write(tbl[i].addr, tbl[i].wdata);
            else begin
                apb_read(tbl[i].addr, got);
                check(tbl[i].name, got, tbl[i].exp);
            end
        end
        m_en = 1;

        // Basic stereo frame after one alignment word
        send_word(32'h1234_5678, 1, 32);
        send_frame(32'hA5A5_0001, 32'h5A5A_0002, 32, 32);
        apb_read(6'h08, got); check("rxl_034", got, 32'hA5A5_0001); void'(ql.pop_front());
        apb_read(6'h0C, got); check("rxr_034", got, 32'h5A5A_0002); void'(qr.pop_front());
        apb_read(6'h04, got); check("sr_034", got, 32'h05);

        // Empty read leaves status unchanged
        apb_read(6'h04, sr_a);
        rd_fifo(0, "rxl_empty_037");
        apb_read(6'h04, got); check("sr_same_037", got, sr_a);

        // Short left word
        send_frame($urandom, 32'hCAFE_0036, 31, 32);
        apb_read(6'h04, got); check("sr_frm_036", got, 32'h21);
        rd_fifo(1, "rxr_036");
        rd_fifo(0, "rxl_036");
        cr_write(32'h3);
        rd_sr("sr_clr_036");

        // Overflow: five frames into four-deep FIFOs
        for (int k = 0; k < 5; k++) send_frame($urandom, $urandom, 32, 32);
        apb_read(6'h04, got); check("sr_ovr_035", got, 32'h1A);
        cr_write(32'h3);
        apb_read(6'h04, got); check("sr_clr_035", got, 32'h0A);
        for (int k = 0; k < 4; k++) rd_fifo(0, "rxl_035");
        for (int k = 0; k < 4; k++) rd_fifo(1, "rxr_035");
        rd_sr("sr_drained_035");

        // Random traffic against the model
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 5))
                0, 1: send_frame($urandom, $urandom, pick_len(), pick_len());
                2: rd_fifo(0, "rnd_rxl");
                3: rd_fifo(1, "rnd_rxr");
                4: rd_sr("rnd_sr");
                default: cr_write(32'h3);
            endcase
        end
        while (ql.size() > 0) rd_fifo(0, "rnd_drain_l");
        while (qr.size() > 0) rd_fifo(1, "rnd_drain_r");
        rd_sr("rnd_sr_end");
        cr_write(32'h3);

        // Reset in the middle of a left word, re-enable mid right word
        l = $urandom; r = $urandom;
        fork
            begin
                send_word(l, 0, 32);
                send_word(r, 1, 32);
            end
            begin
                wait (tx_ch == 0 && tx_pos == 16);
                rst_n = 0;
                #1;
                check("mid_rst_prdata", bus.prdata, 32'h0);
                check("mid_rst_pready", {31'd0, bus.pready}, 32'h1);
                ql.delete(); qr.delete();
                m_ovr = 0; m_frm = 0; m_en = 0; armed = 0;
                apb_read(6'h04, got); check("sr_in_rst_038", got, 32'h05);
                @(negedge clk) rst_n = 1;
                apb_read(6'h00, got); check("cr_after_rst_038", got, 32'h0);
                apb_read(6'h04, got); check("sr_after_rst_038", got, 32'h05);
                wait (tx_ch == 1 && tx_pos == 16);
                cr_write(32'h1);
            end
        join
        send_frame($urandom, $urandom, 32, 32);
        rd_sr("sr_two_038");
        rd_fifo(0, "rxl_038");
        rd_fifo(1, "rxr_038");
        rd_sr("sr_end_038");

`ifdef APB_I2S_RX_IRQ_EN
        cr_write(32'h5);
        repeat (3) @(negedge clk);
        check("irq_idle", {31'd0, irq}, 32'h0);
        send_frame($urandom, $urandom, 32, 32);
        repeat (3) @(negedge clk);
        check("irq_frame", {31'd0, irq}, 32'h1);
        rd_fifo(0, "irq_rxl");
        rd_fifo(1, "irq_rxr");
        repeat (3) @(negedge clk);
        check("irq_cleared", {31'd0, irq}, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
